decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high.
REQ-003 SHALL have ports: stop  in  1  global pause, same net as fetch stop source; command  in  32  instruction from fetch; now_pc  in  32  PC of command.
REQ-004 SHALL have ports: flush  in  1  branch/jump taken downstream (same event as fetch bubble+wb_pc); wb_en  in  1; wb_rd  in  5; wb_data  in  32  register write-back.
REQ-005 SHALL have outputs: stall_req  out  1  load-use stall, ORed into fetch stop; d_pc  out  32; d_opcode  out  7; d_funct3  out  3; d_funct7b5  out  1; d_rd, d_rs1, d_rs2  out  5 each.
REQ-006 SHALL have outputs: d_imm  out  32; d_rs1_data, d_rs2_data  out  32 each; d_mem_read, d_mem_write, d_reg_write, d_illegal  out  1 each.

Function
REQ-007 SHALL register every d_* output; one-cycle latency from command to d_*.
REQ-008 SHALL hold a 32x32 register file; x0 reads 0 always; write at posedge when wb_en and wb_rd!=0, independent of stop/flush/stall.
REQ-009 SHALL bypass write-back to reads: if wb_en, wb_rd!=0, wb_rd==rs, read value is wb_data same cycle.
REQ-010 SHALL generate d_imm sign-extended per RV32I type: I (OP-IMM, LOAD, JALR), S (STORE), B (BRANCH, bit0=0), U (LUI, AUIPC, low 12 zero), J (JAL, bit0=0); other opcodes -> 0.
REQ-011 SHALL set d_mem_read = LOAD, d_mem_write = STORE, d_reg_write = (LUI|AUIPC|JAL|JALR|LOAD|OP-IMM|OP) and rd!=0.
REQ-012 SHALL set d_illegal=1 for opcodes outside RV32I base set (incl. FENCE/SYSTEM accepted as legal); illegal instruction forces d_reg_write, d_mem_read, d_mem_write to 0.
REQ-013 SHALL define rs1-use = all opcodes except LUI, AUIPC, JAL; rs2-use = BRANCH, STORE, OP.
REQ-014 SHALL assert stall_req combinationally when d_mem_read=1, d_rd!=0, and (rs1-use and command.rs1==d_rd, or rs2-use and command.rs2==d_rd).
REQ-015 SHALL define bubble load = NOP: d_opcode=0010011, d_rd/rs1/rs2/funct3/funct7b5=0, d_imm=0, data=0, all control bits 0; d_pc unchanged.
REQ-016 SHALL update per cycle with priority: reset > stop (all d_* hold) > flush (bubble load) > stall_req (bubble load) > normal decode of command.
REQ-017 SHALL keep stall_req asserted at most one cycle per load (bubble clears d_mem_read); command/now_pc held by fetch during stall and decoded next cycle.
REQ-018 SHALL deassert stall_req while stop=1 or flush=1 (flush kills dependent instruction).
REQ-019 SHALL treat stall_req computed during reset as 0.

Reset
REQ-020 SHALL on reset load bubble values into all d_*, set d_pc=0, clear all 32 registers to 0, regardless of stop/flush.
REQ-021 SHALL have stall_req=0 in cycle after reset; reset mid-stall cancels stall.

Verification
REQ-022 ADDI: reg x1 via wb (wb_rd=1, 0x5); command addi x2,x1,-3 (0xFFD08113) -> next cycle d_rs1_data=5, d_imm=0xFFFFFFFD, d_rd=2, d_reg_write=1.
REQ-023 Load-use: lw x3,0(x1) then add x4,x3,x2 -> stall_req=1 one cycle, d_* bubble, then add decoded with d_rs1=3; stall_req 0 after.
REQ-024 Bypass: wb_en=1 wb_rd=7 wb_data=0xDEADBEEF same cycle as command reading x7 -> d_rs1_data=0xDEADBEEF; wb_rd=0 -> x0 still reads 0.
REQ-025 Flush+stop: flush=1 with valid sw -> d_mem_write=0, NOP; stop=1 for 3 cycles -> d_* unchanged, stall_req=0.
REQ-026 Immediates/illegal: B beq offset -8, J jal offset 0x800, U lui 0x12345 -> d_imm 0xFFFFFFF8, 0x00000800, 0x12345000; opcode 0000000 -> d_illegal=1, d_reg_write=0.
REQ-027 Reset mid-operation: reset during load-use stall -> next cycle all d_* bubble, d_pc=0, register x1 reads 0, stall_req=0.

Source files
------------

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage: register file, immediate/control decode, load-use stall.
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stop,
    input  logic [31:0] command,
    input  logic [31:0] now_pc,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        stall_req,
    output logic [31:0] d_pc,
    output logic [6:0]  d_opcode,
    output logic [2:0]  d_funct3,
    output logic        d_funct7b5,
    output logic [4:0]  d_rd,
    output logic [4:0]  d_rs1,
    output logic [4:0]  d_rs2,
    output logic [31:0] d_imm,
    output logic [31:0] d_rs1_data,
    output logic [31:0] d_rs2_data,
    output logic        d_mem_read,
    output logic        d_mem_write,
    output logic        d_reg_write,
    output logic        d_illegal
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [31:0] regs [32];

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        legal;
    logic        writes_rd;
    logic        rs1_use;
    logic        rs2_use;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;

    assign opcode = command[6:0];
    assign rd     = command[11:7];
    assign rs1    = command[19:15];
    assign rs2    = command[24:20];

    always_comb begin
        imm       = 32'd0;
        legal     = 1'b1;
        writes_rd = 1'b0;
        rs1_use   = 1'b1;
        rs2_use   = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                imm       = {command[31:12], 12'd0};
                writes_rd = 1'b1;
                rs1_use   = 1'b0;
            end
            OP_JAL: begin
                imm       = {{12{command[31]}}, command[19:12], command[20], command[30:21], 1'b0};
                writes_rd = 1'b1;
                rs1_use   = 1'b0;
            end
            OP_JALR, OP_LOAD, OP_IMM: begin
                imm       = {{20{command[31]}}, command[31:20]};
                writes_rd = 1'b1;
            end
            OP_STORE: begin
                imm     = {{20{command[31]}}, command[31:25], command[11:7]};
                rs2_use = 1'b1;
            end
            OP_BRANCH: begin
                imm     = {{20{command[31]}}, command[7], command[30:25], command[11:8], 1'b0};
                rs2_use = 1'b1;
            end
            OP_OP: begin
                writes_rd = 1'b1;
                rs2_use   = 1'b1;
            end
            OP_FENCE, OP_SYSTEM: begin
                legal = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    // Write-back bypass: a same-cycle write to the source register wins over the array.
    assign rs1_data = (rs1 == 5'd0) ? 32'd0 : ((wb_en && wb_rd == rs1) ? wb_data : regs[rs1]);
    assign rs2_data = (rs2 == 5'd0) ? 32'd0 : ((wb_en && wb_rd == rs2) ? wb_data : regs[rs2]);

    assign stall_req = !reset && !stop && !flush && d_mem_read && (d_rd != 5'd0) &&
                       ((rs1_use && rs1 == d_rd) || (rs2_use && rs2 == d_rd));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (wb_en && wb_rd != 5'd0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // A bubble is an ADDI x0,x0,0 with no side effects; it keeps d_pc except on reset.
    always_ff @(posedge clk) begin
        if (reset || (!stop && (flush || stall_req))) begin
            if (reset) begin
                d_pc <= 32'd0;
            end
            d_opcode    <= OP_IMM;
            d_funct3    <= 3'd0;
            d_funct7b5  <= 1'b0;
            d_rd        <= 5'd0;
            d_rs1       <= 5'd0;
            d_rs2       <= 5'd0;
            d_imm       <= 32'd0;
            d_rs1_data  <= 32'd0;
            d_rs2_data  <= 32'd0;
            d_mem_read  <= 1'b0;
            d_mem_write <= 1'b0;
            d_reg_write <= 1'b0;
            d_illegal   <= 1'b0;
        end else if (!stop) begin
            d_pc        <= now_pc;
            d_opcode    <= opcode;
            d_funct3    <= command[14:12];
            d_funct7b5  <= command[30];
            d_rd        <= rd;
            d_rs1       <= rs1;
            d_rs2       <= rs2;
            d_imm       <= imm;
            d_rs1_data  <= rs1_data;
            d_rs2_data  <= rs2_data;
            d_mem_read  <= (opcode == OP_LOAD);
            d_mem_write <= (opcode == OP_STORE);
            d_reg_write <= writes_rd && (rd != 5'd0);
            d_illegal   <= !legal;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed and randomized check of decode_stage against a reference model.
module tb_decode_stage;

    logic        clk;
    logic        reset;
    logic        stop;
    logic [31:0] command;
    logic [31:0] now_pc;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall_req;
    logic [31:0] d_pc;
    logic [6:0]  d_opcode;
    logic [2:0]  d_funct3;
    logic        d_funct7b5;
    logic [4:0]  d_rd;
    logic [4:0]  d_rs1;
    logic [4:0]  d_rs2;
    logic [31:0] d_imm;
    logic [31:0] d_rs1_data;
    logic [31:0] d_rs2_data;
    logic        d_mem_read;
    logic        d_mem_write;
    logic        d_reg_write;
    logic        d_illegal;

    decode_stage dut (
        .clk(clk), .reset(reset), .stop(stop), .command(command), .now_pc(now_pc),
        .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall_req(stall_req), .d_pc(d_pc), .d_opcode(d_opcode), .d_funct3(d_funct3),
        .d_funct7b5(d_funct7b5), .d_rd(d_rd), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_imm(d_imm),
        .d_rs1_data(d_rs1_data), .d_rs2_data(d_rs2_data), .d_mem_read(d_mem_read),
        .d_mem_write(d_mem_write), .d_reg_write(d_reg_write), .d_illegal(d_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        f7b5;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic        mr;
        logic        mw;
        logic        rw;
        logic        ill;
    } dec_t;

    dec_t        m;
    logic [31:0] mreg [32];
    logic        exp_stall;
    logic        obs_stall;
    int          total;
    int          bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (wb_en && wb_rd == r) return wb_data;
        return mreg[r];
    endfunction

    function automatic dec_t bubble(input logic [31:0] pc);
        dec_t b;
        b.pc = pc; b.opcode = 7'h13; b.funct3 = 3'd0; b.f7b5 = 1'b0;
        b.rd = 5'd0; b.rs1 = 5'd0; b.rs2 = 5'd0; b.imm = 32'd0;
        b.rs1d = 32'd0; b.rs2d = 32'd0; b.mr = 1'b0; b.mw = 1'b0; b.rw = 1'b0; b.ill = 1'b0;
        return b;
    endfunction

    // Immediates are rebuilt as signed offsets: sum of weighted fields minus the sign weight.
    function automatic dec_t ref_decode(input logic [31:0] c, input logic [31:0] pc);
        dec_t r;
        logic [6:0] op;
        op = c[6:0];
        r.pc = pc; r.opcode = op; r.funct3 = c[14:12]; r.f7b5 = c[30];
        r.rd = c[11:7]; r.rs1 = c[19:15]; r.rs2 = c[24:20];
        r.rs1d = model_read(c[19:15]);
        r.rs2d = model_read(c[24:20]);
        case (op)
            7'h13, 7'h03, 7'h67:
                r.imm = 32'(c[31:20]) - (c[31] ? 32'd4096 : 32'd0);
            7'h23:
                r.imm = 32'(c[11:7]) + 32'(c[31:25]) * 32 - (c[31] ? 32'd4096 : 32'd0);
            7'h63:
                r.imm = 32'(c[11:8]) * 2 + 32'(c[30:25]) * 32 + 32'(c[7]) * 2048
                        - (c[31] ? 32'd4096 : 32'd0);
            7'h37, 7'h17:
                r.imm = c & 32'hFFFF_F000;
            7'h6F:
                r.imm = 32'(c[30:21]) * 2 + 32'(c[20]) * 2048 + 32'(c[19:12]) * 4096
                        - (c[31] ? 32'h0010_0000 : 32'd0);
            default:
                r.imm = 32'd0;
        endcase
        r.ill = !(op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73});
        r.mr  = (op == 7'h03);
        r.mw  = (op == 7'h23);
        r.rw  = (op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33}) && (c[11:7] != 5'd0);
        return r;
    endfunction

    function automatic logic model_stall();
        logic [6:0] op;
        logic       u1;
        logic       u2;
        op = command[6:0];
        u1 = !(op inside {7'h37, 7'h17, 7'h6F});
        u2 = op inside {7'h63, 7'h23, 7'h33};
        return !reset && !stop && !flush && m.mr && (m.rd != 5'd0) &&
               ((u1 && command[19:15] == m.rd) || (u2 && command[24:20] == m.rd));
    endfunction

    task automatic check_outputs();
        check("d_pc", d_pc, m.pc);
        check("d_opcode", 32'(d_opcode), 32'(m.opcode));
        check("d_funct3", 32'(d_funct3), 32'(m.funct3));
        check("d_funct7b5", 32'(d_funct7b5), 32'(m.f7b5));
        check("d_rd", 32'(d_rd), 32'(m.rd));
        check("d_rs1", 32'(d_rs1), 32'(m.rs1));
        check("d_rs2", 32'(d_rs2), 32'(m.rs2));
        check("d_imm", d_imm, m.imm);
        check("d_rs1_data", d_rs1_data, m.rs1d);
        check("d_rs2_data", d_rs2_data, m.rs2d);
        check("ctrl", {28'd0, d_mem_read, d_mem_write, d_reg_write, d_illegal},
                      {28'd0, m.mr, m.mw, m.rw, m.ill});
    endtask

    // One clock: check stall mid-cycle, advance the model at the edge, check d_* after it.
    task automatic cycle();
        logic [31:0] keep_pc;
        #1;
        exp_stall = model_stall();
        obs_stall = stall_req;
        check("stall_req", 32'(stall_req), 32'(exp_stall));
        @(posedge clk);
        if (reset) begin
            m = bubble(32'd0);
            for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
        end else begin
            if (!stop) begin
                keep_pc = m.pc;
                if (flush || exp_stall) m = bubble(keep_pc);
                else m = ref_decode(command, now_pc);
            end
            if (wb_en && wb_rd != 5'd0) mreg[wb_rd] = wb_data;
        end
        #1;
        check_outputs();
    endtask

    task automatic drive(input logic [31:0] c);
        command = c;
        now_pc  = now_pc + 32'd4;
    endtask

    function automatic logic [31:0] rand_cmd();
        logic [6:0]  ops [12];
        logic [31:0] c;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h00};
        c = $urandom;
        c[6:0]   = ops[$urandom_range(0, 11)];
        if ($urandom_range(0, 9) == 0) c[6:0] = 7'($urandom);
        c[11:7]  = 5'($urandom_range(0, 3));
        c[19:15] = 5'($urandom_range(0, 3));
        c[24:20] = 5'($urandom_range(0, 3));
        return c;
    endfunction

    initial begin
        total = 0; bad = 0;
        reset = 1'b1; stop = 1'b0; flush = 1'b0; command = 32'h0000_0013; now_pc = 32'h100;
        wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        cycle();
        cycle();
        check("reset_pc", d_pc, 32'd0);
        check("reset_opcode", 32'(d_opcode), 32'h13);
        reset = 1'b0;

        // ADDI x2,x1,-3 after writing x1=5
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd5; drive(32'h0000_0013);
        cycle();
        wb_en = 1'b0; drive(32'hFFD0_8113);
        cycle();
        check("addi_rs1_data", d_rs1_data, 32'd5);
        check("addi_imm", d_imm, 32'hFFFF_FFFD);
        check("addi_rd", 32'(d_rd), 32'd2);
        check("addi_reg_write", 32'(d_reg_write), 32'd1);

        // Load-use: lw x3,0(x1) ; add x4,x3,x2
        drive(32'h0000_A183);
        cycle();
        drive(32'h0021_8233);
        cycle();
        check("lu_stall", 32'(obs_stall), 32'd1);
        check("lu_bubble_op", 32'(d_opcode), 32'h13);
        check("lu_bubble_mr", 32'(d_mem_read), 32'd0);
        cycle();
        check("lu_stall_clear", 32'(obs_stall), 32'd0);
        check("lu_add_rs1", 32'(d_rs1), 32'd3);
        check("lu_add_op", 32'(d_opcode), 32'h33);
        drive(32'h0000_0013);
        cycle();
        check("lu_after", 32'(obs_stall), 32'd0);

        // Bypass on x7, then wb_rd=0 leaves x0 at zero
        wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEAD_BEEF; drive(32'h0003_8413);
        cycle();
        check("bypass_x7", d_rs1_data, 32'hDEAD_BEEF);
        wb_rd = 5'd0; wb_data = 32'h1234_5678; drive(32'h0000_0413);
        cycle();
        check("x0_zero", d_rs1_data, 32'd0);
        wb_en = 1'b0;

        // Flush kills a store; stop holds a load with a dependent command waiting
        flush = 1'b1; drive(32'h0020_A023);
        cycle();
        check("flush_mw", 32'(d_mem_write), 32'd0);
        check("flush_op", 32'(d_opcode), 32'h13);
        flush = 1'b0; drive(32'h0000_A183);
        cycle();
        stop = 1'b1; drive(32'h0021_8233);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("stop_stall", 32'(obs_stall), 32'd0);
            check("stop_hold_op", 32'(d_opcode), 32'h03);
        end
        stop = 1'b0;
        cycle();
        cycle();

        // Immediates and an illegal opcode
        drive(32'hFE00_0CE3); cycle(); check("imm_b", d_imm, 32'hFFFF_FFF8);
        drive(32'h0010_006F); cycle(); check("imm_j", d_imm, 32'h0000_0800);
        drive(32'h1234_52B7); cycle(); check("imm_u", d_imm, 32'h1234_5000);
        drive(32'h0000_0080); cycle();
        check("illegal", 32'(d_illegal), 32'd1);
        check("illegal_rw", 32'(d_reg_write), 32'd0);

        // Reset during a load-use stall
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd9; drive(32'h0000_0013);
        cycle();
        wb_en = 1'b0; drive(32'h0000_A183);
        cycle();
        reset = 1'b1; drive(32'h0021_8233);
        cycle();
        check("rst_stall", 32'(obs_stall), 32'd0);
        check("rst_pc", d_pc, 32'd0);
        check("rst_op", 32'(d_opcode), 32'h13);
        reset = 1'b0; drive(32'h0000_8413);
        cycle();
        check("rst_x1", d_rs1_data, 32'd0);
        check("rst_stall_after", 32'(obs_stall), 32'd0);

        // Randomized traffic; fetch holds its command while stalled or stopped
        for (int n = 0; n < 600; n++) begin
            if (!(exp_stall || stop)) drive(rand_cmd());
            reset   = ($urandom_range(0, 59) == 0);
            stop    = ($urandom_range(0, 7) == 0);
            flush   = ($urandom_range(0, 9) == 0);
            wb_en   = $urandom_range(0, 1) == 1;
            wb_rd   = 5'($urandom_range(0, 4) == 0 ? $urandom : $urandom_range(0, 3));
            wb_data = $urandom;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
